// File: rtl/instr_encoder.sv
//------------------------------------------------------------------------------
//  Module      : instr_encoder
//  Description : Packs RV32I instruction fields into 32-bit words. Each word
//                is tagged with a running target address and queued in a
//                2-entry FIFO behind a valid/ready output handshake.
//                Optional build macro ENCODER_FIELD_CHECK_EN: when it is
//                defined, the encoder also rejects immediates that cannot be
//                represented in the selected format.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam logic [2:0] c_FMT_R = 3'd0;
  localparam logic [2:0] c_FMT_I = 3'd1;
  localparam logic [2:0] c_FMT_S = 3'd2;
  localparam logic [2:0] c_FMT_B = 3'd3;
  localparam logic [2:0] c_FMT_U = 3'd4;
  localparam logic [2:0] c_FMT_J = 3'd5;
  localparam logic [1:0] c_DEPTH = 2'd2;

  logic [31:0] r_instr_mem [2];
  logic [31:0] r_addr_mem  [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_addr_ctr;
  logic        r_err;

  logic [31:0] w_instr;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Pack the fields of the selected format; unused fields never reach the word.
  always_comb begin
    w_instr = '0;
    case (fmt)
      c_FMT_R: w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      c_FMT_I: w_instr = {imm[11:0], rs1, funct3, rd, opcode};
      c_FMT_S: w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      c_FMT_B: w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      c_FMT_U: w_instr = {imm[31:12], rd, opcode};
      c_FMT_J: w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_instr = '0;
    endcase
  end

  // Decide whether the offered bundle becomes a word or raises err.
  always_comb begin
    w_legal = 1'b0;
`ifdef ENCODER_FIELD_CHECK_EN
    // Immediates must fit the format: upper bits a pure sign extension,
    // branch/jump offsets halfword aligned, U low bits empty.
    case (fmt)
      c_FMT_R: w_legal = 1'b1;
      c_FMT_I,
      c_FMT_S: w_legal = (&imm[31:11]) | ~(|imm[31:11]);
      c_FMT_B: w_legal = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      c_FMT_U: w_legal = ~(|imm[11:0]);
      c_FMT_J: w_legal = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      default: w_legal = 1'b0;
    endcase
`else
    // Out-of-range immediates are truncated; only reserved formats fail.
    w_legal = (fmt <= c_FMT_J);
`endif
  end

  // A base reload owns the cycle, so no bundle is taken alongside it.
  assign in_ready  = (r_count < c_DEPTH) && !load_base;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign out_instr = r_instr_mem[r_rd_ptr];
  assign out_addr  = r_addr_mem[r_rd_ptr];
  assign err       = r_err;

  // FIFO storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_mem[0] <= '0;
      r_instr_mem[1] <= '0;
      r_addr_mem[0]  <= '0;
      r_addr_mem[1]  <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= w_instr;
        r_addr_mem[r_wr_ptr]  <= r_addr_ctr;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Address counter: reload wins, otherwise advance one word per pushed entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_ctr <= RESET_ADDR;
    end else if (load_base) begin
      r_addr_ctr <= base_addr;
    end else if (w_push) begin
      r_addr_ctr <= r_addr_ctr + 32'd4;
    end
  end

  // One-cycle err pulse for a bundle taken by the handshake but not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//------------------------------------------------------------------------------
//  Module      : tb_instr_encoder
//  Description : Directed, table-driven bench for instr_encoder with hand
//                sequences for backpressure, reload/wrap and reset flush.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        legal;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        load_base;
  logic [31:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr;
  vec_t tbl [12];
  vec_t va, vb, vc;

  instr_encoder #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .load_base(load_base), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; imm = v.imm;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [31:0] im,
                              input logic [31:0] e, input logic lg);
    vec_t v;
    v.fmt = f; v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = r1; v.rs2 = r2;
    v.rd = d; v.imm = im; v.exp = e; v.legal = lg;
    return v;
  endfunction

  initial begin
    // R add-style, addi, sw, beq, jal, lui, illegal fmt, and ignored-field cases
    tbl[0]  = mk(3'd0, 7'b0110011, 3'd0, 7'b0100000, 5'd10, 5'd21, 5'd17, 32'hDEAD_BEEF, 32'h415508B3, 1'b1);
    tbl[1]  = mk(3'd1, 7'b0010011, 3'd0, 7'h7F,      5'd0,  5'd31, 5'd1,  32'd5,        32'h00500093, 1'b1);
    tbl[2]  = mk(3'd2, 7'b0100011, 3'd2, 7'h7F,      5'd1,  5'd2,  5'd31, 32'd8,        32'h0020A423, 1'b1);
    tbl[3]  = mk(3'd3, 7'b1100011, 3'd0, 7'h00,      5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFE000EE3, 1'b1);
    tbl[4]  = mk(3'd5, 7'b1101111, 3'd0, 7'h00,      5'd0,  5'd0,  5'd1,  32'd8,        32'h008000EF, 1'b1);
    tbl[5]  = mk(3'd4, 7'b0110111, 3'd7, 7'h7F,      5'd9,  5'd9,  5'd5,  32'h1234_5000, 32'h123452B7, 1'b1);
    tbl[6]  = mk(3'd6, 7'b0110011, 3'd0, 7'h00,      5'd1,  5'd2,  5'd3,  32'd0,        32'h0,        1'b0);
    tbl[7]  = mk(3'd0, 7'b0110011, 3'd7, 7'h00,      5'd3,  5'd4,  5'd5,  32'h0,        32'h0041F2B3, 1'b1);
    tbl[8]  = mk(3'd7, 7'b0110011, 3'd0, 7'h00,      5'd1,  5'd2,  5'd3,  32'd0,        32'h0,        1'b0);
    tbl[9]  = mk(3'd1, 7'b0010011, 3'd0, 7'h00,      5'd2,  5'd0,  5'd3,  32'hFFFF_FFFF, 32'hFFF10193, 1'b1);
`ifdef ENCODER_FIELD_CHECK_EN
    tbl[10] = mk(3'd3, 7'b1100011, 3'd0, 7'h00,      5'd0,  5'd0,  5'd0,  32'd3,        32'h0,        1'b0);
    tbl[11] = mk(3'd4, 7'b0110111, 3'd0, 7'h00,      5'd0,  5'd0,  5'd5,  32'h1234_5001, 32'h0,       1'b0);
`else
    tbl[10] = mk(3'd3, 7'b1100011, 3'd0, 7'h00,      5'd0,  5'd0,  5'd0,  32'd3,        32'h00000163, 1'b1);
    tbl[11] = mk(3'd4, 7'b0110111, 3'd0, 7'h00,      5'd0,  5'd0,  5'd5,  32'h1234_5001, 32'h123452B7, 1'b1);
`endif

    reset = 1'b1; in_valid = 1'b0; load_base = 1'b0; base_addr = '0; out_ready = 1'b1;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream with out_ready=1: each word appears one cycle after accept.
    exp_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      #1 chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      if (tbl[i].legal) begin
        chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("v%0d_instr", i), out_instr, tbl[i].exp);
        chk($sformatf("v%0d_addr", i), out_addr, exp_addr);
        chk($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
        exp_addr = exp_addr + 32'd4;
      end else begin
        chk($sformatf("v%0d_err", i), {31'd0, err}, 32'd1);
        chk($sformatf("v%0d_novalid", i), {31'd0, out_valid}, 32'd0);
      end
    end
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("err_pulse_end", {31'd0, err}, 32'd0);

    // Backpressure: three offered, two taken, head stable, third after one pop.
    va = mk(3'd0, 7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd10, 32'd0, 32'h00208533, 1'b1);
    vb = mk(3'd0, 7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd11, 32'd0, 32'h002085B3, 1'b1);
    vc = mk(3'd0, 7'b0110011, 3'd0, 7'h00, 5'd1, 5'd2, 5'd12, 32'd0, 32'h00208633, 1'b1);
    out_ready = 1'b0;
    drive(va); tick();
    drive(vb); tick();
    drive(vc);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_head_stable", out_instr, va.exp);
    chk("bp_head_addr", out_addr, exp_addr);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_after_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_second", out_instr, vb.exp);
    chk("bp_second_addr", out_addr, exp_addr + 32'd4);
    tick();
    in_valid = 1'b0;
    chk("bp_third", out_instr, vc.exp);
    chk("bp_third_addr", out_addr, exp_addr + 32'd8);
    chk("bp_pushpop_count", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    exp_addr = exp_addr + 32'd12;

    // Reload keeps queued tags, then wrap from FFFF_FFFC to 0.
    out_ready = 1'b0;
    drive(va); tick();
    in_valid = 1'b0;
    load_base = 1'b1; base_addr = 32'hFFFF_FFFC;
    #1 chk("load_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    load_base = 1'b0;
    chk("load_keeps_tag", out_addr, exp_addr);
    out_ready = 1'b1;
    tick();
    drive(va); tick();
    chk("wrap_tag0", out_addr, 32'hFFFF_FFFC);
    drive(vb); tick();
    chk("wrap_tag1", out_addr, 32'h0000_0000);
    drive(tbl[8]); tick();
    in_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_nopush", {31'd0, out_valid}, 32'd0);
    drive(vc); tick();
    in_valid = 1'b0;
    chk("ill_err_clear", {31'd0, err}, 32'd0);
    chk("ill_ctr_hold", out_addr, 32'h0000_0004);
    tick();

    // Reset with two words queued flushes them and restarts the counter.
    out_ready = 1'b0;
    drive(va); tick();
    drive(vb); tick();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_addr", out_addr, 32'd0);
    reset = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(vc); tick();
    in_valid = 1'b0;
    chk("post_rst_tag", out_addr, 32'h0);
    chk("post_rst_instr", out_instr, vc.exp);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0000_0000, address-counter value after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  field bundle valid.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a bundle.
REQ-006 SHALL have port fmt  input  3  format select: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6-7 illegal.
REQ-007 SHALL have ports opcode  input  7, funct3  input  3, funct7  input  7, rs1/rs2/rd  input  5 each; these are the instruction fields.
REQ-008 SHALL have port imm  input  32  full sign-extended immediate; B/J carry a byte offset.
REQ-009 SHALL have ports load_base  input  1 and base_addr  input  32; these reload the address counter.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1, which form the output handshake.
REQ-011 SHALL have ports out_instr  output  32 and out_addr  output  32, which carry the encoded word and its target address.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a bundle is rejected.

Function
REQ-013 SHALL accept a bundle on a cycle where in_valid and in_ready are both 1; SHALL transfer out on a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL pack fields per the RV32I base formats: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-015 SHALL ignore fields unused by the selected format.
REQ-016 SHALL buffer encoded words in a 2-entry FIFO, in order; in_ready = (count < 2) and not load_base.
REQ-017 SHALL produce 1-cycle latency: a word accepted in cycle N is visible at the FIFO head, with out_valid=1, in cycle N+1 when the FIFO was empty.
REQ-018 SHALL hold out_instr and out_addr stable while out_valid=1 and out_ready=0.
REQ-019 SHALL leave count unchanged on a simultaneous push and pop at count 1.
REQ-020 SHALL tag each accepted legal word with the current address counter, then increment the counter by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-021 SHALL load the address counter with base_addr when load_base=1; in_ready is 0 that cycle, and FIFO contents keep their tags.
REQ-022 SHALL complete the handshake for an illegal bundle (fmt 6-7) but not push it, not advance the counter, and pulse err in the next cycle.
REQ-023 SHALL drive out_instr and out_addr from the FIFO head entry; their values are don't-care when out_valid=0.

Reset
REQ-024 SHALL, on reset, set FIFO count 0, out_valid 0, out_instr 0, out_addr 0, err 0, and the address counter to RESET_ADDR.
REQ-025 SHALL give reset priority over any simultaneous handshake or load_base; words in flight are discarded.
REQ-026 SHALL drive in_ready 1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, when ENCODER_FIELD_CHECK_EN is defined, also reject bundles that fail any of these checks: I/S imm[31:11] not all-equal; B imm[31:12] not all-equal or imm[0]=1; J imm[31:20] not all-equal or imm[0]=1; U imm[11:0] nonzero. Rejection follows REQ-022.
REQ-028 SHALL, when ENCODER_FIELD_CHECK_EN is undefined, silently truncate out-of-range immediates per REQ-014; err then fires only for fmt 6-7.

Verification
REQ-029 SHALL cover R-type: fmt 0, funct7 0100000, rs2 21, rs1 10, funct3 0, rd 17, opcode 0110011, out_ready=1 -> out_instr 32'h415508B3 with out_addr RESET_ADDR one cycle later.
REQ-030 SHALL cover a back-to-back burst: I addi x1,x0,5 (imm 5) then S sw x2,8(x1) -> 32'h00500093 @0, 32'h0020A423 @4.
REQ-031 SHALL cover B/J/U: beq x0,x0,imm -4 -> 32'hFE000EE3; jal x1,imm 8 -> 32'h008000EF; lui x5,imm 32'h12345000 -> 32'h123452B7.
REQ-032 SHALL cover backpressure: out_ready=0 with 3 bundles offered -> two accepted, in_ready 0, head stable; one pop -> third accepted; order preserved.
REQ-033 SHALL cover wrap and reload: load_base with 32'hFFFF_FFFC, then two words -> tags FFFF_FFFC then 0000_0000; fmt 7 -> err pulse, no push, counter unchanged.
REQ-034 SHALL cover checks: with ENCODER_FIELD_CHECK_EN, B imm 3 -> err and no word; without it -> word emitted with imm[0] dropped. Reset asserted with 2 words queued -> out_valid 0 next cycle.
